// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine trap-entry block holding mcause, mepc, mtval and mtvec.
// Prioritises synchronous exceptions over interrupts, latches the winning trap,
// holds it until the pipeline reports flush_done_in, then commits it to the CSRs
// and pulses a fetch redirect to the trap vector. Also redirects fetch to mepc
// one cycle after an mret retires.
//
// Ports:
//   clock, rst_in            rising-edge clock, synchronous active-high reset
//   exc_req_in [NUM_EXC]     exception requests (source i -> cause i)
//   irq_in [NUM_INT]         level interrupts (line j -> cause 4*j+3)
//   irq_en_in                global interrupt enable
//   pc_in, tval_in           faulting PC and trap value
//   flush_done_in            pipeline drained, trap may commit
//   mret_in                  mret retiring
//   wr_en_in, csr_addr_in, data_wr_in   CSR write port
//   csr_rd_data_out, csr_hit_out        combinational CSR read port
//   mcause_out, mepc_out, mtval_out, mtvec_out, cause_out, int_or_exc_out
//   trap_pending_out         trap latched, waiting for flush
//   redirect_valid_out, redirect_pc_out fetch redirect pulse and target
module trap_csr_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     CAUSE_W   = 4,
    parameter int unsigned     NUM_EXC   = 8,
    parameter int unsigned     NUM_INT   = 3,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [11:0]     MCAUSE    = 12'h342,
    parameter logic [11:0]     MEPC      = 12'h341,
    parameter logic [11:0]     MTVAL     = 12'h343,
    parameter logic [11:0]     MTVEC     = 12'h305
) (
    input  logic               clock,
    input  logic               rst_in,
    input  logic [NUM_EXC-1:0] exc_req_in,
    input  logic [NUM_INT-1:0] irq_in,
    input  logic               irq_en_in,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [XLEN-1:0]    tval_in,
    input  logic               flush_done_in,
    input  logic               mret_in,
    input  logic               wr_en_in,
    input  logic [11:0]        csr_addr_in,
    input  logic [XLEN-1:0]    data_wr_in,
    output logic [XLEN-1:0]    csr_rd_data_out,
    output logic               csr_hit_out,
    output logic [XLEN-1:0]    mcause_out,
    output logic [XLEN-1:0]    mepc_out,
    output logic [XLEN-1:0]    mtval_out,
    output logic [XLEN-1:0]    mtvec_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               int_or_exc_out,
    output logic               trap_pending_out,
    output logic               redirect_valid_out,
    output logic [XLEN-1:0]    redirect_pc_out
);

    typedef enum logic [1:0] {IDLE, HOLD, COMMIT} state_t;

    state_t state_q, state_d;

    logic               exc_any, irq_any, req;
    logic [CAUSE_W-1:0] exc_code, int_code;

    logic [CAUSE_W-1:0] lat_code;
    logic               lat_int;
    logic [XLEN-1:0]    lat_pc, lat_tval;

    logic [CAUSE_W-1:0] mcause_code;
    logic               mcause_int;
    logic [XLEN-1:0]    mepc_q, mtval_q, mtvec_q;
    logic               mret_q;

    logic               commit_edge;
    logic               wr_mcause, wr_mepc, wr_mtval, wr_mtvec;

    // Exceptions: lowest index wins (scan high to low, last hit sticks).
    // Interrupts: highest index wins (scan low to high, last hit sticks).
    always_comb begin
        exc_any  = |exc_req_in;
        irq_any  = irq_en_in & (|irq_in);
        req      = exc_any | irq_any;
        exc_code = '0;
        int_code = '0;
        for (int unsigned i = 0; i < NUM_EXC; i++) begin
            if (exc_req_in[NUM_EXC-1-i])
                exc_code = CAUSE_W'(NUM_EXC-1-i);
        end
        for (int unsigned j = 0; j < NUM_INT; j++) begin
            if (irq_in[j])
                int_code = CAUSE_W'(4*j+3);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = HOLD;
            HOLD:    if (flush_done_in) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign commit_edge = (state_q == HOLD) && flush_done_in;
    assign wr_mcause   = wr_en_in && (csr_addr_in == MCAUSE);
    assign wr_mepc     = wr_en_in && (csr_addr_in == MEPC);
    assign wr_mtval    = wr_en_in && (csr_addr_in == MTVAL);
    assign wr_mtvec    = wr_en_in && (csr_addr_in == MTVEC);

    always_ff @(posedge clock) begin
        if (rst_in) begin
            state_q     <= IDLE;
            lat_code    <= '0;
            lat_int     <= 1'b0;
            lat_pc      <= '0;
            lat_tval    <= '0;
            mcause_code <= '0;
            mcause_int  <= 1'b0;
            mepc_q      <= '0;
            mtval_q     <= '0;
            mtvec_q     <= RESET_VEC;
            mret_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            mret_q  <= (state_q == IDLE) && mret_in && !req;

            if (state_q == IDLE && req) begin
                lat_code <= exc_any ? exc_code : int_code;
                lat_int  <= !exc_any;
                lat_pc   <= pc_in;
                lat_tval <= exc_any ? tval_in : '0;
            end

            // A committing trap overrides a same-edge software write.
            if (commit_edge) begin
                mcause_code <= lat_code;
                mcause_int  <= lat_int;
                mepc_q      <= lat_pc;
                mtval_q     <= lat_tval;
            end else begin
                if (wr_mcause) begin
                    mcause_code <= data_wr_in[CAUSE_W-1:0];
                    mcause_int  <= data_wr_in[XLEN-1];
                end
                if (wr_mepc)  mepc_q  <= {data_wr_in[XLEN-1:2], 2'b00};
                if (wr_mtval) mtval_q <= data_wr_in;
            end

            // Modes 2/3 are reserved: keep the current mode, still take the base.
            if (wr_mtvec) begin
                mtvec_q[XLEN-1:2] <= data_wr_in[XLEN-1:2];
                if (!data_wr_in[1])
                    mtvec_q[1:0] <= data_wr_in[1:0];
            end
        end
    end

    assign mcause_out     = {mcause_int, {(XLEN-1-CAUSE_W){1'b0}}, mcause_code};
    assign mepc_out       = mepc_q;
    assign mtval_out      = mtval_q;
    assign mtvec_out      = mtvec_q;
    assign cause_out      = mcause_code;
    assign int_or_exc_out = mcause_int;

    assign trap_pending_out   = (state_q == HOLD);
    assign redirect_valid_out = (state_q == COMMIT) || mret_q;

    always_comb begin
        redirect_pc_out = '0;
        if (state_q == COMMIT) begin
            redirect_pc_out = {mtvec_q[XLEN-1:2], 2'b00};
            if (mtvec_q[1:0] == 2'b01 && lat_int)
                redirect_pc_out = redirect_pc_out + XLEN'({lat_code, 2'b00});
        end else if (mret_q) begin
            redirect_pc_out = mepc_q;
        end
    end

    always_comb begin
        csr_hit_out     = 1'b1;
        csr_rd_data_out = '0;
        case (csr_addr_in)
            MCAUSE:  csr_rd_data_out = mcause_out;
            MEPC:    csr_rd_data_out = mepc_q;
            MTVAL:   csr_rd_data_out = mtval_q;
            MTVEC:   csr_rd_data_out = mtvec_q;
            default: csr_hit_out     = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_trap_csr_unit.sv
module tb_trap_csr_unit;

    logic        clock = 1'b0;
    logic        rst_in = 1'b1;
    logic [7:0]  exc_req_in = '0;
    logic [2:0]  irq_in = '0;
    logic        irq_en_in = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] tval_in = '0;
    logic        flush_done_in = 1'b0;
    logic        mret_in = 1'b0;
    logic        wr_en_in = 1'b0;
    logic [11:0] csr_addr_in = '0;
    logic [31:0] data_wr_in = '0;
    logic [31:0] csr_rd_data_out, mcause_out, mepc_out, mtval_out, mtvec_out, redirect_pc_out;
    logic        csr_hit_out, int_or_exc_out, trap_pending_out, redirect_valid_out;
    logic [3:0]  cause_out;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    trap_csr_unit #(.XLEN(32), .CAUSE_W(4), .NUM_EXC(8), .NUM_INT(3), .RESET_VEC(32'h0)) dut (
        .clock(clock), .rst_in(rst_in), .exc_req_in(exc_req_in), .irq_in(irq_in),
        .irq_en_in(irq_en_in), .pc_in(pc_in), .tval_in(tval_in), .flush_done_in(flush_done_in),
        .mret_in(mret_in), .wr_en_in(wr_en_in), .csr_addr_in(csr_addr_in), .data_wr_in(data_wr_in),
        .csr_rd_data_out(csr_rd_data_out), .csr_hit_out(csr_hit_out), .mcause_out(mcause_out),
        .mepc_out(mepc_out), .mtval_out(mtval_out), .mtvec_out(mtvec_out), .cause_out(cause_out),
        .int_or_exc_out(int_or_exc_out), .trap_pending_out(trap_pending_out),
        .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out)
    );

    always #5 clock = ~clock;

    // Redirect scoreboard: every pulse must match the oldest expected target.
    always @(negedge clock) begin
        if (!rst_in && redirect_valid_out) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL redirect_unexpected: got pc=%h, required no redirect", redirect_pc_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (redirect_pc_out !== e) begin
                    n_fail++;
                    $display("FAIL redirect_pc: got %h, required %h", redirect_pc_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        wr_en_in = 1'b1; csr_addr_in = a; data_wr_in = d;
        tick();
        wr_en_in = 1'b0; data_wr_in = '0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(); tick();
        rst_in = 1'b0;
        n_checks++;
        if ({mcause_out, mepc_out, mtval_out, mtvec_out} !== 128'h0 ||
            trap_pending_out !== 1'b0 || redirect_valid_out !== 1'b0 || redirect_pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got mcause=%h mepc=%h mtval=%h mtvec=%h pend=%b rv=%b, required all 0",
                     mcause_out, mepc_out, mtval_out, mtvec_out, trap_pending_out, redirect_valid_out);
        end
        csr_addr_in = 12'h7C0; #1;
        n_checks++;
        if (csr_hit_out !== 1'b0 || csr_rd_data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL csr_miss: got hit=%b data=%h, required hit=0 data=0", csr_hit_out, csr_rd_data_out);
        end
    endtask

    task automatic test_priority();
        csr_write(12'h305, 32'h0000_1000);
        exc_req_in = 8'b0010_0100; irq_in = 3'b111; irq_en_in = 1'b1;
        pc_in = 32'h100; tval_in = 32'hDEAD; flush_done_in = 1'b1;
        exp_q.push_back(32'h0000_1000);
        tick();
        exc_req_in = '0; irq_in = '0; irq_en_in = 1'b0; tval_in = '0;
        n_checks++;
        if (trap_pending_out !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_pending: got %b, required 1", trap_pending_out);
        end
        tick();
        n_checks++;
        if (mcause_out !== 32'h2 || mepc_out !== 32'h100 || mtval_out !== 32'hDEAD ||
            redirect_valid_out !== 1'b1 || trap_pending_out !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_commit: got mcause=%h mepc=%h mtval=%h rv=%b pend=%b, required 2/100/dead/1/0",
                     mcause_out, mepc_out, mtval_out, redirect_valid_out, trap_pending_out);
        end
        flush_done_in = 1'b0;
        tick();
        n_checks++;
        if (redirect_valid_out !== 1'b0 || redirect_pc_out !== 32'h0) begin
            n_fail++;
            $display("FAIL prio_single_pulse: got rv=%b pc=%h, required 0/0", redirect_valid_out, redirect_pc_out);
        end
    endtask

    task automatic test_vectored();
        csr_write(12'h305, 32'h0000_2001);
        irq_in = 3'b010; irq_en_in = 1'b1; pc_in = 32'h0000_0ABC; tval_in = 32'h1234;
        exp_q.push_back(32'h0000_201C);
        tick();
        irq_in = '0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (trap_pending_out !== 1'b1 || redirect_valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_hold[%0d]: got pend=%b rv=%b, required 1/0", i, trap_pending_out, redirect_valid_out);
            end
            if (i == 4) flush_done_in = 1'b1;
            tick();
        end
        flush_done_in = 1'b0;
        n_checks++;
        if (mcause_out !== 32'h8000_0007 || cause_out !== 4'd7 || int_or_exc_out !== 1'b1 ||
            mepc_out !== 32'h0ABC || mtval_out !== 32'h0) begin
            n_fail++;
            $display("FAIL vec_commit: got mcause=%h mepc=%h mtval=%h, required 80000007/abc/0",
                     mcause_out, mepc_out, mtval_out);
        end
        tick();
        irq_in = 3'b010; irq_en_in = 1'b0; flush_done_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (trap_pending_out !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_masked[%0d]: got pend=%b, required 0", i, trap_pending_out);
            end
        end
        irq_in = '0; flush_done_in = 1'b0;
    endtask

    task automatic test_mret();
        csr_write(12'h341, 32'h0000_0403);
        csr_addr_in = 12'h341; #1;
        n_checks++;
        if (csr_hit_out !== 1'b1 || csr_rd_data_out !== 32'h400) begin
            n_fail++;
            $display("FAIL mepc_warl: got hit=%b data=%h, required 1/00000400", csr_hit_out, csr_rd_data_out);
        end
        mret_in = 1'b1;
        exp_q.push_back(32'h0000_0400);
        tick();
        mret_in = 1'b0;
        n_checks++;
        if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 32'h400) begin
            n_fail++;
            $display("FAIL mret_redirect: got rv=%b pc=%h, required 1/00000400", redirect_valid_out, redirect_pc_out);
        end
        tick();
        // mret collides with an exception: trap wins, mret is dropped.
        mret_in = 1'b1; exc_req_in = 8'b0000_0010; pc_in = 32'h500; tval_in = 32'h77; flush_done_in = 1'b1;
        exp_q.push_back(32'h0000_2000);
        tick();
        mret_in = 1'b0; exc_req_in = '0;
        n_checks++;
        if (redirect_valid_out !== 1'b0 || trap_pending_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mret_collide: got rv=%b pend=%b, required 0/1", redirect_valid_out, trap_pending_out);
        end
        tick();
        flush_done_in = 1'b0;
        n_checks++;
        if (mcause_out !== 32'h1 || mepc_out !== 32'h500 || mtval_out !== 32'h77) begin
            n_fail++;
            $display("FAIL mret_collide_commit: got mcause=%h mepc=%h mtval=%h, required 1/500/77",
                     mcause_out, mepc_out, mtval_out);
        end
        tick();
    endtask

    task automatic test_warl();
        csr_write(12'h342, 32'hFFFF_FFFF);
        csr_addr_in = 12'h342; #1;
        n_checks++;
        if (csr_rd_data_out !== 32'h8000_000F) begin
            n_fail++;
            $display("FAIL mcause_warl: got %h, required 8000000f", csr_rd_data_out);
        end
        csr_write(12'h343, 32'hA5A5_5A5B);
        n_checks++;
        if (mtval_out !== 32'hA5A5_5A5B) begin
            n_fail++;
            $display("FAIL mtval_write: got %h, required a5a55a5b", mtval_out);
        end
        csr_write(12'h305, 32'h0000_1001);
        csr_write(12'h305, 32'h0000_3003);
        csr_addr_in = 12'h305; #1;
        n_checks++;
        if (csr_rd_data_out !== 32'h0000_3001) begin
            n_fail++;
            $display("FAIL mtvec_warl: got %h, required 00003001", csr_rd_data_out);
        end
    endtask

    task automatic test_collision_reset();
        // Exception, mcause software write on the edge entering COMMIT.
        exc_req_in = 8'b0000_1000; pc_in = 32'h600; tval_in = 32'h99; flush_done_in = 1'b1;
        exp_q.push_back(32'h0000_3000);
        tick();
        exc_req_in = '0;
        wr_en_in = 1'b1; csr_addr_in = 12'h342; data_wr_in = 32'h5;
        tick();
        wr_en_in = 1'b0; flush_done_in = 1'b0;
        n_checks++;
        if (mcause_out !== 32'h3 || redirect_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_cause: got mcause=%h rv=%b, required 3/1", mcause_out, redirect_valid_out);
        end
        tick();
        // Reset while a trap is held: no redirect may follow.
        exc_req_in = 8'b0000_0001; pc_in = 32'h700;
        tick();
        exc_req_in = '0;
        n_checks++;
        if (trap_pending_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_pending: got %b, required 1", trap_pending_out);
        end
        rst_in = 1'b1; flush_done_in = 1'b1;
        tick();
        rst_in = 1'b0;
        n_checks++;
        if ({mcause_out, mepc_out, mtval_out} !== 96'h0 || mtvec_out !== 32'h0 ||
            trap_pending_out !== 1'b0 || redirect_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_hold: got mcause=%h mepc=%h mtval=%h mtvec=%h pend=%b rv=%b, required all 0",
                     mcause_out, mepc_out, mtval_out, mtvec_out, trap_pending_out, redirect_valid_out);
        end
        tick(); tick(); tick();
        flush_done_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_vectored();
        test_mret();
        test_warl();
        test_collision_reset();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL redirect_missing: got %0d unconsumed expected redirects, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Parametrised trap-entry unit that generalises the single machine-cause register into a full machine trap block: mcause, mepc, mtval and mtvec.
- Adds prioritisation of multiple exception sources and interrupt lines, plus a sequential trap-entry handshake with the pipeline (hold until flush, then redirect).
- Handles mret return redirection.
- Sits beside the CSR file and is driven by the core pipeline's exception and flush logic.

Parameters:
- XLEN, 32, data and CSR width.
- CAUSE_W, 4, implemented low bits of the mcause code field. Requires NUM_EXC <= 2^CAUSE_W and CAUSE_W >= 4.
- NUM_EXC, 8, number of synchronous exception sources. Source i has cause code i.
- NUM_INT, 3, number of interrupt lines. Line j has cause code 4*j+3.
- RESET_VEC, 32'h0000_0000, reset value of mtvec.
- MCAUSE, 12'h342; MEPC, 12'h341; MTVAL, 12'h343; MTVEC, 12'h305: CSR addresses.

Ports:
- clock  in  1  clock, rising edge.
- rst_in  in  1  synchronous, active-high reset.
- exc_req_in  in  NUM_EXC  exception requests, one bit per source.
- irq_in  in  NUM_INT  level interrupt requests.
- irq_en_in  in  1  global interrupt enable (mstatus.MIE).
- pc_in  in  XLEN  PC of the faulting/interrupted instruction.
- tval_in  in  XLEN  trap value accompanying an exception.
- flush_done_in  in  1  pipeline drained, trap may commit.
- mret_in  in  1  mret retiring.
- wr_en_in  in  1  CSR write strobe.
- csr_addr_in  in  12  CSR address.
- data_wr_in  in  XLEN  CSR write data.
- csr_rd_data_out  out  XLEN  combinational read data; 0 on address miss.
- csr_hit_out  out  1  csr_addr_in matches one of the four CSRs.
- mcause_out, mepc_out, mtval_out, mtvec_out  out  XLEN  register contents.
- cause_out  out  CAUSE_W  mcause code field.
- int_or_exc_out  out  1  mcause[XLEN-1].
- trap_pending_out  out  1  trap latched, waiting for flush.
- redirect_valid_out  out  1  one-cycle pulse: fetch must jump.
- redirect_pc_out  out  XLEN  jump target; 0 when redirect_valid_out=0.

Behaviour:

Reset:
- Synchronous; all registers and outputs go to 0, except mtvec which goes to RESET_VEC.
- FSM returns to IDLE. Reset mid-operation drops any latched trap with no redirect.

Request qualification:
- Qualified request = |exc_req_in | (irq_en_in & |irq_in).
- Exceptions beat interrupts.
- Among exceptions, the lowest index wins.
- Among interrupts, the highest index wins.

FSM states: IDLE, HOLD, COMMIT.
- IDLE + qualified request:
  - Latch code, interrupt flag, pc_in, and tval (tval_in for exceptions, 0 for interrupts).
  - Next state HOLD; trap_pending_out=1 from the following cycle.
  - Request inputs are ignored while in HOLD or COMMIT.
- IDLE + mret_in with no request:
  - Next cycle redirect_valid_out=1 and redirect_pc_out=mepc. State stays IDLE.
  - A request in the same cycle as mret wins; the mret is dropped.
- HOLD:
  - Wait for flush_done_in=1, then go to COMMIT.
  - On the edge entering COMMIT, write the latched values to mcause, mepc and mtval.
- COMMIT (exactly 1 cycle):
  - redirect_valid_out=1; trap_pending_out=0; next state IDLE.
  - New values are visible on mcause_out/mepc_out/mtval_out in this same cycle.
  - redirect_pc_out = {mtvec[XLEN-1:2],2'b00}, plus 4*code when mtvec[1:0]=01 and the trap is an interrupt.
  - Target uses the mtvec value held during COMMIT.
- Minimum latency: request in cycle N, flush_done_in high in N+1, redirect pulse in N+2.

CSR writes (WARL) while wr_en_in=1:
- mcause: code = data[CAUSE_W-1:0]; bit XLEN-1 = data[XLEN-1]; all bits in between read 0.
- mepc: bits [1:0] forced to 0.
- mtval: full width.
- mtvec:
  - Base bits [XLEN-1:2] are always written.
  - Mode 00 or 01 is written as given.
  - Mode 10 or 11 leaves the mode field unchanged.
- Priority: a trap commit on the same edge beats a software write to mcause/mepc/mtval.
- Writes are accepted in any state, including HOLD.
- A write to mtvec on the edge entering COMMIT takes effect, so the COMMIT target uses the new mtvec.

Test Plan:
- Priority: exc_req_in=8'b0010_0100 with irq_in=3'b111, irq_en_in=1, pc_in=32'h100, tval_in=32'hDEAD, flush_done_in held high -> after 2 cycles, mcause=32'h2, mepc=32'h100, mtval=32'hDEAD, one redirect pulse to mtvec base.
- Vectored interrupt: mtvec written 32'h0000_2001, irq_in=3'b010, irq_en_in=1, flush_done_in delayed 5 cycles -> trap_pending_out high for 5 cycles, then mcause=32'h8000_0007 and redirect_pc_out=32'h2000+28=32'h201C; with irq_en_in=0 there is no trap.
- mret: mepc written 32'h0000_0403 -> reads back 32'h400. mret_in pulse -> next cycle redirect_valid_out=1, redirect_pc_out=32'h400. mret and exc_req_in[1] in the same cycle -> trap taken, no mret redirect.
- WARL: write mcause 32'hFFFF_FFFF -> reads 32'h8000_000F. Write mtvec 32'h0000_3003 after 32'h0000_1001 -> reads 32'h0000_3001.
- Collision and reset: software write to mcause on the edge entering COMMIT -> the trap cause wins. rst_in asserted during HOLD -> no redirect, all registers read 0, mtvec = RESET_VEC.
